mp3_track_scheduler: RTL and testbench

Sequences and shares the single MP3 SPI driver between several sound tracks stored back-to-back in one music ROM. Game logic pulses per-track play requests. The scheduler picks the highest-priority pending track and restarts the driver for it. It offsets the driver's local address into that track's ROM region and detects end of track. It sits between game control logic and `mp3_driver`. The driver's `MUSIC_SIZE` is set to at least the largest track length.

---
 rtl/mp3_sched_pkg.sv | 22 ++
 rtl/mp3_prio_pick.sv | 37 +++
 rtl/mp3_track_scheduler.sv | 139 +++++++++++++
 tb/tb_mp3_track_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_sched_pkg.sv
// Shared types and the music ROM track table for mp3_track_scheduler.
// Tracks sit back-to-back in the ROM; each base is the sum of the earlier lengths.
package mp3_sched_pkg;

  localparam int SCHED_NUM_TRACKS = 4;
  localparam int SCHED_ADDR_W     = 21;
  localparam int TRACK_IDX_W      = $clog2(SCHED_NUM_TRACKS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESTART,
    ST_PLAY,
    ST_DONE
  } sched_state_e;

  localparam logic [SCHED_ADDR_W-1:0] TRACK_BASE [SCHED_NUM_TRACKS] =
    '{21'd0, 21'd29432, 21'd32432, 21'd33932};

  localparam logic [SCHED_ADDR_W-1:0] TRACK_LEN [SCHED_NUM_TRACKS] =
    '{21'd29432, 21'd3000, 21'd1500, 21'd800};

endpackage

// File: rtl/mp3_prio_pick.sv
// Combinational highest-set-bit encoder over the pending request vector.
// With mask_en high only bits strictly above cur_track are candidates.
module mp3_prio_pick
  import mp3_sched_pkg::*;
#(
  parameter int N     = SCHED_NUM_TRACKS,
  parameter int IDX_W = TRACK_IDX_W
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] cur_track,
  input  logic             mask_en,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0] cand;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = pending[gi] && (!mask_en || (IDX_W'(gi) > cur_track));
    end
  endgenerate

  // Ascending scan so the last (highest) candidate wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mp3_track_scheduler.sv
// Shares one mp3_driver between prioritised tracks in a single music ROM.
// Optional feature macro: MP3_SCHED_PREEMPT_EN (higher-priority requests cut the current track).
module mp3_track_scheduler
  import mp3_sched_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter int ADDR_W     = 21,
  parameter int RST_CYCLES = 4,
  parameter int BG_LOOP    = 1
) (
  input  logic                          mp3_clk,
  input  logic                          rst_n,
  input  logic                          sched_en,
  input  logic [NUM_TRACKS-1:0]         play_req,
  input  logic [ADDR_W-1:0]             drv_addr,
  input  logic                          drv_music_over,
  output logic                          drv_rst,
  output logic [ADDR_W-1:0]             rom_addr,
  output logic [$clog2(NUM_TRACKS)-1:0] cur_track,
  output logic                          playing,
  output logic                          track_done,
  output logic [$clog2(NUM_TRACKS)-1:0] done_track
);

  localparam int IDX_W    = $clog2(NUM_TRACKS);
  localparam int RST_LOAD = (RST_CYCLES < 1) ? 1 : RST_CYCLES;
  localparam int CNT_W    = $clog2(RST_LOAD + 1);

  sched_state_e          state_q, state_d;
  logic [NUM_TRACKS-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]      cur_track_q, cur_track_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_TRACKS-1:0] clr_mask, set_mask;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic                  end_cond;
  logic                  bg_requeue;

  mp3_prio_pick #(.N(NUM_TRACKS), .IDX_W(IDX_W)) u_pick (
    .pending   (pending_q),
    .cur_track (cur_track_q),
    .mask_en   (1'b0),
    .valid     (pick_valid),
    .idx       (pick_idx)
  );

`ifdef MP3_SCHED_PREEMPT_EN
  logic             pre_valid;
  logic [IDX_W-1:0] pre_idx;

  mp3_prio_pick #(.N(NUM_TRACKS), .IDX_W(IDX_W)) u_pick_hi (
    .pending   (pending_q),
    .cur_track (cur_track_q),
    .mask_en   (1'b1),
    .valid     (pre_valid),
    .idx       (pre_idx)
  );
`endif

  assign rom_addr   = ADDR_W'(TRACK_BASE[cur_track_q]) + drv_addr;
  assign end_cond   = (drv_addr >= ADDR_W'(TRACK_LEN[cur_track_q])) || drv_music_over;
  assign bg_requeue = (BG_LOOP != 0) && (cur_track_q == '0);
  assign cur_track  = cur_track_q;

  always_comb begin
    state_d     = state_q;
    cur_track_d = cur_track_q;
    cnt_d       = cnt_q;
    clr_mask    = '0;
    set_mask    = '0;
    drv_rst     = 1'b1;
    playing     = 1'b0;
    track_done  = 1'b0;
    done_track  = '0;

    case (state_q)
      ST_IDLE: begin
        if (sched_en && pick_valid) begin
          cur_track_d        = pick_idx;
          clr_mask[pick_idx] = 1'b1;
          cnt_d              = CNT_W'(RST_LOAD);
          state_d            = ST_RESTART;
        end
      end
      ST_RESTART: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        drv_rst = 1'b0;
        playing = 1'b1;
`ifdef MP3_SCHED_PREEMPT_EN
        if (pre_valid) begin
          cur_track_d       = pre_idx;
          clr_mask[pre_idx] = 1'b1;
          set_mask[0]       = bg_requeue;
          cnt_d             = CNT_W'(RST_LOAD);
          state_d           = ST_RESTART;
        end else
`endif
        if (end_cond) state_d = ST_DONE;
      end
      ST_DONE: begin
        track_done  = 1'b1;
        done_track  = cur_track_q;
        set_mask[0] = bg_requeue;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable parks in IDLE without consuming any request.
    if (!sched_en) begin
      state_d     = ST_IDLE;
      cur_track_d = cur_track_q;
      cnt_d       = cnt_q;
      clr_mask    = '0;
      drv_rst     = 1'b1;
    end

    // A pick in the same cycle as a new request for that track merges them.
    pending_d = ((pending_q | play_req) & ~clr_mask) | set_mask;
  end

  always_ff @(posedge mp3_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      cur_track_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      cur_track_q <= cur_track_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mp3_track_scheduler.sv
// Directed bench for mp3_track_scheduler; completed tracks are checked against a scoreboard queue.
module tb_mp3_track_scheduler;

  localparam int NT = 4;
  localparam int AW = 21;
  localparam int RC = 4;

  logic          mp3_clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          sched_en = 1'b0;
  logic [NT-1:0] play_req = '0;
  logic [AW-1:0] drv_addr = '0;
  logic          drv_music_over = 1'b0;
  logic          drv_rst;
  logic [AW-1:0] rom_addr;
  logic [1:0]    cur_track;
  logic          playing;
  logic          track_done;
  logic [1:0]    done_track;

  int tests = 0;
  int fails = 0;
  int sb_q[$];
  int n_ticks;
  int n_rst;

  always #5 mp3_clk = ~mp3_clk;

  mp3_track_scheduler #(
    .NUM_TRACKS(NT), .ADDR_W(AW), .RST_CYCLES(RC), .BG_LOOP(1)
  ) dut (
    .mp3_clk        (mp3_clk),
    .rst_n          (rst_n),
    .sched_en       (sched_en),
    .play_req       (play_req),
    .drv_addr       (drv_addr),
    .drv_music_over (drv_music_over),
    .drv_rst        (drv_rst),
    .rom_addr       (rom_addr),
    .cur_track      (cur_track),
    .playing        (playing),
    .track_done     (track_done),
    .done_track     (done_track)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock; outputs sampled 1 time unit after the edge, completions popped from the scoreboard.
  task automatic tick();
    int exp_t;
    @(posedge mp3_clk);
    #1;
    if (track_done === 1'b1) begin
      tests++;
      assert (sb_q.size() != 0) else begin
        fails++;
        $error("FAIL spurious_done observed=%0d expected=none", done_track);
      end
      if (sb_q.size() != 0) begin
        exp_t = sb_q.pop_front();
        chk("done_track", done_track, exp_t);
      end
    end
  endtask

  task automatic pulse(input logic [NT-1:0] r);
    play_req = r;
    tick();
    play_req = '0;
  endtask

  task automatic wait_play(input string tag);
    n_ticks = 0;
    n_rst   = 0;
    for (int i = 0; i < 60 && playing !== 1'b1; i++) begin
      tick();
      n_ticks++;
      if (drv_rst === 1'b1 && playing !== 1'b1) n_rst++;
    end
    chk(tag, playing, 1);
  endtask

  task automatic finish_track(input int trk);
    sb_q.push_back(trk);
    drv_music_over = 1'b1;
    tick();
    drv_music_over = 1'b0;
    chk("done_pulse", track_done, 1);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (playing !== 1'b0) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_drv_rst", drv_rst, 1);
    chk("rst_playing", playing, 0);
    chk("rst_track_done", track_done, 0);
    chk("rst_cur_track", cur_track, 0);
    chk("rst_done_track", done_track, 0);
    tick();
    tick();
    rst_n    = 1'b1;
    sched_en = 1'b1;
    tick();

    // Single request: latency, ROM offset, end at TRACK_LEN
    pulse(4'b0010);
    wait_play("single_play");
    chk("single_latency", n_ticks + 1, 2 + RC);
    chk("single_cur", cur_track, 1);
    chk("single_rom0", rom_addr, 29432);
    drv_addr = 21'd100;
    #1;
    chk("single_rom100", rom_addr, 29532);
    drv_addr = 21'd2999;
    tick();
    chk("single_len_m1", playing, 1);
    sb_q.push_back(1);
    drv_addr = 21'd3000;
    tick();
    chk("single_done", track_done, 1);
    drv_addr = '0;
    idle_check("single_idle", 8);

    // Merge: request lands in the same cycle as the pick
    play_req = 4'b0100;
    tick();
    tick();
    play_req = '0;
    wait_play("merge_play");
    chk("merge_cur", cur_track, 2);
    chk("merge_rom", rom_addr, 32432);
    finish_track(2);
    idle_check("merge_once", 12);

    // Replay: request for the playing track is latched
    pulse(4'b0100);
    wait_play("replay_first");
    pulse(4'b0100);
    tick();
    chk("replay_still", playing, 1);
    finish_track(2);
    wait_play("replay_play");
    chk("replay_cur", cur_track, 2);
    finish_track(2);
    idle_check("replay_once", 12);

    // Higher-priority request during track 1
    pulse(4'b0010);
    wait_play("pre_t1_play");
    chk("pre_t1_cur", cur_track, 1);
`ifdef MP3_SCHED_PREEMPT_EN
    pulse(4'b1000);
    tick();
    chk("preempt_playing", playing, 0);
    chk("preempt_drv_rst", drv_rst, 1);
    chk("preempt_cur", cur_track, 3);
    wait_play("preempt_play");
`else
    pulse(4'b1000);
    repeat (5) tick();
    chk("defer_still", playing, 1);
    chk("defer_cur", cur_track, 1);
    sb_q.push_back(1);
    drv_addr = 21'd3000;
    tick();
    chk("defer_t1_done", track_done, 1);
    drv_addr = '0;
    wait_play("defer_play");
    chk("defer_gap", n_ticks, 2 + RC);
`endif
    chk("t3_cur", cur_track, 3);
    drv_addr = 21'd5;
    #1;
    chk("t3_rom", rom_addr, 33937);
    drv_addr = '0;
    finish_track(3);
    idle_check("t3_idle", 8);

    // Priority pick, then background loop of track 0
    pulse(4'b0101);
    wait_play("prio_first");
    chk("prio_cur2", cur_track, 2);
    finish_track(2);
    wait_play("prio_second");
    chk("prio_cur0", cur_track, 0);
    chk("prio_rst_gap", n_rst + 1, 2 + RC);
    finish_track(0);
    wait_play("bg_replay");
    chk("bg_cur", cur_track, 0);
    chk("bg_rst_cycles", n_rst + 1, 2 + RC);

    // Asynchronous reset mid-play
    rst_n = 1'b0;
    #1;
    chk("arst_drv_rst", drv_rst, 1);
    chk("arst_playing", playing, 0);
    chk("arst_cur", cur_track, 0);
    tick();
    rst_n = 1'b1;
    idle_check("arst_pending_clear", 12);

    // Disable mid-play keeps pending requests
    pulse(4'b0100);
    wait_play("dis_play");
    chk("dis_cur", cur_track, 2);
    pulse(4'b0010);
    sched_en = 1'b0;
    tick();
    chk("dis_playing", playing, 0);
    chk("dis_drv_rst", drv_rst, 1);
    idle_check("dis_hold", 6);
    sched_en = 1'b1;
    wait_play("dis_resume");
    chk("dis_resume_cur", cur_track, 1);
    finish_track(1);
    idle_check("dis_idle", 8);

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
